// File: rtl/data_cache.sv
// data_cache: two-way set-associative, write-back, write-allocate data cache.
// A miss stalls the core while the FSM writes back a dirty victim and refills the line.
module data_cache #(
    parameter int WIDTH       = 32,
    parameter int SETS        = 64,
    parameter int BLOCK_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [2:0]       modeBU,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic [WIDTH-1:0] cpu_rd,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    input  logic             mem_ack
);
    localparam int WO_B  = $clog2(BLOCK_WORDS);
    localparam int IDX_B = $clog2(SETS);
    localparam int WOW   = (WO_B > 0) ? WO_B : 1;
    localparam int IXW   = (IDX_B > 0) ? IDX_B : 1;
    localparam int TAG_B = WIDTH - 2 - WO_B - IDX_B;
    localparam logic [WOW-1:0] LAST_WORD = WOW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_e;

    state_e         state_q, state_d;
    logic [WOW-1:0] cnt_q, cnt_d;
    logic           vway_q, vway_d;

    logic [WIDTH-1:0]     data_q [2][SETS][BLOCK_WORDS];
    logic [TAG_B-1:0]     tag_q  [2][SETS];
    logic [1:0][SETS-1:0] valid_q, dirty_q;
    logic [SETS-1:0]      lru_q;

    logic [IXW-1:0]   idx;
    logic [WOW-1:0]   woff;
    logic [TAG_B-1:0] rtag, atag;
    logic [1:0]       hit_w;
    logic             req, hit, hway, vway_new, vdirty, hit_go, refill_ack, last;
    logic [WIDTH-1:0] hword, ld_val, st_word, xfer_addr;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

    assign idx  = IXW'((cpu_addr >> (2 + WO_B)) & WIDTH'(SETS - 1));
    assign woff = WOW'((cpu_addr >> 2) & WIDTH'(BLOCK_WORDS - 1));
    assign rtag = TAG_B'(cpu_addr >> (2 + WO_B + IDX_B));

    assign req      = cpu_re | cpu_we;
    assign hit_w[0] = valid_q[0][idx] && (tag_q[0][idx] == rtag);
    assign hit_w[1] = valid_q[1][idx] && (tag_q[1][idx] == rtag);
    assign hit      = |hit_w;
    assign hway     = ~hit_w[0];
    // Invalid ways are filled first (way 0 preferred) before LRU is consulted.
    assign vway_new = ~valid_q[0][idx] ? 1'b0 : (~valid_q[1][idx] ? 1'b1 : lru_q[idx]);
    assign vdirty   = valid_q[vway_new][idx] & dirty_q[vway_new][idx];

    assign hit_go     = (state_q == S_IDLE) && req && hit;
    assign refill_ack = (state_q == S_REFILL) && mem_ack;
    assign last       = (cnt_q == LAST_WORD);

    assign hword = data_q[hway][idx][woff];

    always_comb begin
        ld_byte = hword[8*cpu_addr[1:0] +: 8];
        ld_half = hword[16*cpu_addr[1] +: 16];
        case (modeBU)
            3'b001:  ld_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b101:  ld_val = {{(WIDTH-8){1'b0}}, ld_byte};
            3'b010:  ld_val = {{(WIDTH-16){ld_half[15]}}, ld_half};
            3'b110:  ld_val = {{(WIDTH-16){1'b0}}, ld_half};
            default: ld_val = hword;
        endcase
        st_word = hword;
        case (modeBU[1:0])
            2'b01:   st_word[8*cpu_addr[1:0] +: 8]  = cpu_wd[7:0];
            2'b10:   st_word[16*cpu_addr[1] +: 16] = cpu_wd[15:0];
            default: st_word = cpu_wd;
        endcase
    end

    assign cpu_rd = (req && hit) ? ld_val : '0;

    assign atag      = (state_q == S_WRITEBACK) ? tag_q[vway_q][idx] : rtag;
    assign xfer_addr = (WIDTH'(atag) << (2 + WO_B + IDX_B)) | (WIDTH'(idx) << (2 + WO_B))
                     | (WIDTH'(cnt_q) << 2);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vway_d   = vway_q;
        stall    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    stall   = 1'b1;
                    vway_d  = vway_new;
                    cnt_d   = '0;
                    state_d = vdirty ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = xfer_addr;
                mem_wd   = data_q[vway_q][idx][cnt_q];
                if (mem_ack) begin
                    cnt_d = last ? '0 : cnt_q + 1'b1;
                    if (last) state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = xfer_addr;
                if (mem_ack) begin
                    cnt_d = last ? '0 : cnt_q + 1'b1;
                    if (last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vway_q  <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vway_q  <= vway_d;
            if (hit_go) begin
                lru_q[idx] <= ~hway;
                if (cpu_we) dirty_q[hway][idx] <= 1'b1;
            end
            if (refill_ack && last) begin
                valid_q[vway_q][idx] <= 1'b1;
                dirty_q[vway_q][idx] <= 1'b0;
            end
        end
    end

    // Line storage carries no reset; the valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hit_go && cpu_we) data_q[hway][idx][woff] <= st_word;
            if (refill_ack) data_q[vway_q][idx][cnt_q] <= mem_rd;
            if (refill_ack && last) tag_q[vway_q][idx] <= rtag;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: random and directed accesses against an architectural memory
// plus a per-set recency list predicting hits, evictions and memory traffic.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst, cpu_re, cpu_we, stall, mem_req, mem_we, mem_ack;
    logic [2:0]  modeBU;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd, mem_addr, mem_wd, mem_rd;

    int n_checks = 0;
    int n_errors = 0;

    data_cache #(.WIDTH(32), .SETS(64), .BLOCK_WORDS(4)) dut (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .modeBU(modeBU),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    logic [31:0] bmem [int unsigned];   // backing memory, word keyed
    logic [31:0] arch [int unsigned];   // what the program should observe
    int unsigned setq [64][$];          // line bases per set, most recent first
    bit          dirty_m [int unsigned];

    int          last_stalls, last_txn;
    logic [31:0] last_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void touch(input int unsigned k);
        if (!bmem.exists(k)) begin
            bmem[k] = $urandom;
            arch[k] = bmem[k];
        end
    endfunction

    function automatic void preload(input int unsigned a, input logic [31:0] v);
        bmem[a >> 2] = v;
        arch[a >> 2] = v;
    endfunction

    function automatic logic [31:0] arch_word(input int unsigned a);
        touch(a >> 2);
        return arch[a >> 2];
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] m,
                                             input logic [31:0] a);
        int unsigned b = (w >> (8 * a[1:0])) & 32'hFF;
        int unsigned h = (w >> (16 * a[1])) & 32'hFFFF;
        case (m)
            3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd5:    return b;
            3'd2:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd6:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] old, input logic [2:0] m,
                                             input logic [31:0] a, input logic [31:0] wd);
        int unsigned sb = 8 * a[1:0];
        int unsigned sh = 16 * a[1];
        case (m[1:0])
            2'b01:   return (old & ~(32'hFF << sb)) | ((wd & 32'hFF) << sb);
            2'b10:   return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            default: return wd;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) setq[i].delete();
        dirty_m.delete();
        arch = bmem;
    endfunction

    task automatic do_access(input bit isw, input logic [2:0] mode, input logic [31:0] addr,
                             input logic [31:0] wd, input int dly, input int abort_acks);
        int unsigned base = addr & 32'hFFFF_FFF0;
        int unsigned s    = (addr >> 4) & 63;
        int          pos  = -1;
        int unsigned ex_addr [$];
        bit          ex_we [$];
        int          exp_stall, stalls, txn, waitc;
        bit          done;
        stalls = 0; txn = 0; waitc = 0; done = 1'b0;
        for (int i = 0; i < setq[s].size(); i++) if (setq[s][i] == base) pos = i;
        if (pos < 0) begin
            if (setq[s].size() == 2 && dirty_m.exists(setq[s][1]))
                for (int i = 0; i < 4; i++) begin
                    ex_addr.push_back(setq[s][1] + 4 * i);
                    ex_we.push_back(1'b1);
                end
            for (int i = 0; i < 4; i++) begin
                ex_addr.push_back(base + 4 * i);
                ex_we.push_back(1'b0);
            end
            exp_stall = 1 + ex_addr.size() * (dly + 1);
        end else begin
            exp_stall = 0;
        end

        cpu_we = isw;
        cpu_re = isw ? 1'($urandom_range(0, 1)) : 1'b1;
        modeBU = mode; cpu_addr = addr; cpu_wd = wd;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req) begin
                    if (txn < ex_addr.size()) begin
                        check_eq("mem_addr", mem_addr, ex_addr[txn]);
                        check_eq("mem_we", 32'(mem_we), 32'(ex_we[txn]));
                    end else begin
                        check_eq("extra_txn", txn, ex_addr.size());
                    end
                    if (waitc == dly) begin
                        waitc = 0;
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            check_eq("mem_wd", mem_wd, arch_word(mem_addr));
                            bmem[mem_addr >> 2] = mem_wd;
                        end else begin
                            touch(mem_addr >> 2);
                            mem_rd = bmem[mem_addr >> 2];
                        end
                        txn++;
                    end else begin
                        waitc++;
                    end
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (abort_acks > 0 && txn == abort_acks) begin
                    cpu_re = 1'b0; cpu_we = 1'b0; rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    @(negedge clk);
                    check_eq("abort_mem_req", 32'(mem_req), 32'd0);
                    check_eq("abort_stall", 32'(stall), 32'd0);
                    @(posedge clk); #1;
                    model_reset();
                    return;
                end
            end
        end
        last_stalls = stalls;
        last_txn    = txn;
        last_rd     = cpu_rd;
        check_eq("stall_cycles", stalls, exp_stall);
        check_eq("txn_count", txn, ex_addr.size());
        if (!isw) check_eq("load_data", cpu_rd, ld_model(arch_word(addr), mode, addr));
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b0;

        if (pos < 0) begin
            if (setq[s].size() == 2) begin
                if (dirty_m.exists(setq[s][1])) dirty_m.delete(setq[s][1]);
                void'(setq[s].pop_back());
            end
        end else begin
            setq[s].delete(pos);
        end
        setq[s].push_front(base);
        if (isw) begin
            dirty_m[base] = 1'b1;
            arch[addr >> 2] = st_model(arch_word(addr), mode, addr, wd);
        end
    endtask

    task automatic idle_cycle(input bit ack);
        mem_ack = ack;
        @(negedge clk);
        check_eq("idle_stall", 32'(stall), 32'd0);
        check_eq("idle_mem_req", 32'(mem_req), 32'd0);
        check_eq("idle_cpu_rd", cpu_rd, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; modeBU = 3'd0;
        cpu_addr = '0; cpu_wd = '0; mem_rd = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wd", mem_wd, 32'd0);
        check_eq("rst_cpu_rd", cpu_rd, 32'd0);
        @(posedge clk); #1;

        // Cold load and a following hit in the same line
        preload(32'h100, 32'h11); preload(32'h104, 32'h22);
        preload(32'h108, 32'h33); preload(32'h10C, 32'h44);
        do_access(1'b0, 3'd0, 32'h100, '0, 0, 0);
        check_eq("cold_stalls", last_stalls, 5);
        check_eq("cold_rd", last_rd, 32'h11);
        do_access(1'b0, 3'd0, 32'h108, '0, 0, 0);
        check_eq("hit_rd", last_rd, 32'h33);

        // Sub-word loads
        do_access(1'b1, 3'd0, 32'h200, 32'h8000_FF7F, 0, 0);
        do_access(1'b0, 3'd1, 32'h200, '0, 0, 0);
        check_eq("lb_200", last_rd, 32'h0000_007F);
        do_access(1'b0, 3'd1, 32'h201, '0, 0, 0);
        check_eq("lb_201", last_rd, 32'hFFFF_FFFF);
        do_access(1'b0, 3'd5, 32'h201, '0, 0, 0);
        check_eq("lbu_201", last_rd, 32'h0000_00FF);
        do_access(1'b0, 3'd2, 32'h202, '0, 0, 0);
        check_eq("lh_202", last_rd, 32'hFFFF_8000);
        do_access(1'b0, 3'd6, 32'h202, '0, 0, 0);
        check_eq("lhu_202", last_rd, 32'h0000_8000);

        // Byte store merge on a hit
        preload(32'h300, 32'hAABB_CCDD);
        do_access(1'b0, 3'd0, 32'h300, '0, 0, 0);
        do_access(1'b1, 3'd1, 32'h301, 32'h5A, 0, 0);
        check_eq("merge_txn", last_txn, 0);
        do_access(1'b0, 3'd0, 32'h300, '0, 0, 0);
        check_eq("merge_rd", last_rd, 32'hAABB_5ADD);

        // LRU replacement in set 0, clean then dirty victim
        do_access(1'b1, 3'd0, 32'h0000, 32'hDEAD_BEEF, 0, 0);
        do_access(1'b0, 3'd0, 32'h1000, '0, 0, 0);
        do_access(1'b0, 3'd0, 32'h0000, '0, 0, 0);
        do_access(1'b0, 3'd0, 32'h2000, '0, 0, 0);
        check_eq("lru_clean_txn", last_txn, 4);
        do_access(1'b0, 3'd0, 32'h3000, '0, 0, 0);
        check_eq("lru_dirty_txn", last_txn, 8);
        check_eq("lru_dirty_stalls", last_stalls, 9);

        // Slow memory: three idle cycles before every ack
        do_access(1'b0, 3'd0, 32'h5040, '0, 3, 0);
        check_eq("slow_stalls", last_stalls, 17);

        // Reset after the second refill ack, then a full refill again
        do_access(1'b0, 3'd0, 32'h6080, '0, 0, 2);
        do_access(1'b0, 3'd0, 32'h6080, '0, 0, 0);
        check_eq("reload_txn", last_txn, 4);

        // Random traffic over a few sets and four tags per set
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 2) << 4)
              | ($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) idle_cycle(1'($urandom_range(0, 1)));
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                      int'($urandom_range(0, 2)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_cache.md
# data_cache

Parametrised two-way set-associative, write-back, write-allocate data cache between the core's load/store path (ALU address, RD2 store data, `modeBU` access mode) and a word-wide backing memory. It supports byte, halfword and word accesses, including sign and zero extension on loads. It stalls the core on a miss while a three-state controller performs victim writeback and line refill over a request/acknowledge handshake. It replaces the direct core-to-`data_memory` connection in the next-generation core.

## Interface
- `WIDTH`, 32: data and address width.
- `SETS`, 64: number of sets; must be a power of two.
- `BLOCK_WORDS`, 4: words per line; must be a power of two, at least 1.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `cpu_re` input 1: load request.
- `cpu_we` input 1: store request; takes priority over `cpu_re` when both are high.
- `modeBU` input 3: access mode.
  - 000: word.
  - 001: byte, sign-extended.
  - 010: half, sign-extended.
  - 101: byte, zero-extended.
  - 110: half, zero-extended.
  - Other codes are treated as word.
- `cpu_addr` input WIDTH: byte address.
- `cpu_wd` input WIDTH: store data. Byte and half stores take the low bits.
- `cpu_rd` output WIDTH: load data, extended per `modeBU`; valid when `stall`=0.
- `stall` output 1: the core must hold its PC and request stable while high.
- `mem_req` output 1: backing-memory transfer request.
- `mem_we` output 1: 1 for a writeback word, 0 for a refill word.
- `mem_addr` output WIDTH: word-aligned address of the current transfer.
- `mem_wd` output WIDTH: writeback data.
- `mem_rd` input WIDTH: refill data; valid while `mem_ack` is high.
- `mem_ack` input 1: completes one word transfer in the cycle it is high.

## Operation
- Address split, from low to high:
  - byte offset [1:0];
  - word offset, log2(BLOCK_WORDS) bits;
  - index, log2(SETS) bits;
  - tag, remaining bits.
- Word accesses ignore `addr[1:0]`; half accesses ignore `addr[0]`.
- Per way, per set: valid bit, dirty bit, tag, BLOCK_WORDS data words. One LRU bit per set; LRU=1 means way 1 is least recently used.
- A hit means a valid way has a matching tag.
- Load hit: `cpu_rd` is combinational from the hit way; the selected byte or half is extended per `modeBU`. On the clock edge the LRU bit points at the other way.
- Store hit: on the clock edge, write only the addressed byte lanes, set the dirty bit and update LRU.
- Miss: the victim is the invalid way if one exists, with way 0 preferred; otherwise the LRU way.
- FSM states:
  - IDLE: a miss with a dirty victim goes to WRITEBACK; a miss with a clean victim goes to REFILL; otherwise stay.
  - WRITEBACK: stream the BLOCK_WORDS victim words, word 0 first, to {victim tag, index, word, 00}. After the last ack, go to REFILL.
  - REFILL: fetch BLOCK_WORDS words from {req tag, index, word, 00}. On the last ack, write the tag, set valid=1 and dirty=0, then go to IDLE.
- Back in IDLE, the held request now hits and completes as a normal hit. The store merge happens here.
- No request (`cpu_re`=`cpu_we`=0): no state change, `stall`=0, `cpu_rd` don't-care.
- No cache-flush operation exists. Dirty data is only written back on eviction.

## Timing
- Reset edge:
  - state becomes IDLE;
  - all valid, dirty and LRU bits clear;
  - word counter becomes 0.
- Outputs after reset: `stall`=0 with no request, `mem_req`=0, `mem_we`=0. `mem_addr`, `mem_wd` and `cpu_rd` are 0 while no request is active.
- Reset mid-WRITEBACK or mid-REFILL aborts the transfer. `mem_req` is low in the cycle after the reset edge, and dirty data is discarded.
- Hit latency is zero wait cycles. `stall`=0 in the request cycle, and the store is committed at that cycle's edge.
- `stall` is combinational and goes high in the same cycle a miss is presented while in IDLE. It stays high in WRITEBACK and REFILL, and drops in the IDLE cycle after REFILL completes.
- `mem_req` is high throughout WRITEBACK and REFILL. `mem_addr`, `mem_wd` and `mem_we` are held stable until `mem_ack`. The word counter advances on each ack, so back-to-back acks transfer one word per cycle.
- Clean miss, with ack every cycle: the request cycle plus BLOCK_WORDS refill cycles, then the hit cycle.
- Dirty miss, with ack every cycle: the request cycle, BLOCK_WORDS writeback cycles, BLOCK_WORDS refill cycles, then the hit cycle.
- `mem_ack` while `mem_req`=0 is ignored.

## Test plan
- **Reset and cold load.** Reset, then load word 0x100 with memory[0x100..0x10C]=0x11,0x22,0x33,0x44.
  - `stall` is high for 5 cycles, with 4 refill requests at 0x100, 0x104, 0x108, 0x10C.
  - Then `cpu_rd`=0x11, and a load from 0x108 hits with `stall`=0 and `cpu_rd`=0x33.
- **Byte/half modes.** Store word 0x8000FF7F at 0x200, then load from 0x200:
  - byte signed: 0x0000007F;
  - byte signed at 0x201: 0xFFFFFFFF;
  - byte unsigned at 0x201: 0x000000FF;
  - half signed at 0x202: 0xFFFF8000;
  - half unsigned at 0x202: 0x00008000.
- **Byte store merge.** Word 0x300=0xAABBCCDD, then store byte 0x5A at 0x301. A word load returns 0xAABB5ADD, and no memory transaction occurs.
- **LRU eviction with writeback** (SETS=64, BLOCK_WORDS=4). Dirty 0x0000 (line cached in a way and dirtied by a store), touch 0x1000 (same set, other way), load 0x0000, then load 0x2000.
  - The victim is 0x1000 (clean), so there is a refill only.
  - Next, load 0x3000. It evicts dirty 0x0000: 4 writes to 0x0000–0x000C come before 4 reads from 0x3000.
- **Slow memory.** Insert 3 idle cycles before each `mem_ack`. `mem_addr` and `mem_req` are held stable, and the miss takes 4×4+1 stall cycles.
- **Reset mid-refill.** Assert `rst` after the 2nd refill ack.
  - Next cycle: `mem_req`=0, `stall`=0.
  - A reload of the same address misses again and performs a full 4-word refill.
